// File: rtl/snn_input_streamer.sv
// Replays a host-loaded 784-pixel image as one FC1 input window per time step of an inference.
// Define SNN_RATE_CODE_EN for LFSR Bernoulli rate coding; otherwise pixels are injected directly as pixel/256.
module snn_input_streamer #(
  parameter int          WIDTH       = 24,
  parameter int          FRAC        = 17,
  parameter int          STEP        = 25,
  parameter int          INPUT_NODES = 784,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             img_we,
  input  logic [9:0]       img_waddr,
  input  logic [7:0]       img_wdata,
  input  logic             start,
  input  logic             spk_en,
  output logic             fc_valid,
  output logic [WIDTH-1:0] fc_data,
  output logic [4:0]       step_idx,
  output logic             busy,
  output logic             done
);

  // state | meaning: IDLE await start, STREAM drive window, WAIT await spk_en, FINISH pulse done
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_FINISH} state_e;

  localparam logic [9:0] NODES     = 10'(INPUT_NODES);
  localparam logic [4:0] STEP_LAST = 5'(STEP - 1);

  if (FRAC < 8) begin : g_bad_frac
    $error("snn_input_streamer: FRAC must be at least 8");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("snn_input_streamer: LFSR_SEED must be non-zero");
  end

  state_e           state_q, state_d;
  logic [9:0]       wc_q, wc_d;
  logic [4:0]       step_q, step_d;
  logic             fc_valid_q, fc_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fc_data_q, fc_data_d;
  logic [WIDTH-1:0] sample;
  logic [7:0]       mem_q [INPUT_NODES];
  logic [7:0]       rd_q;
  logic [9:0]       rd_addr;
  logic             rd_en;
  logic             win_start;
  logic             pix_cycle;

  // Buffer is never reset so an image survives a mid-inference reset.
  always_ff @(posedge clk) begin
    if (img_we && !busy_q && (img_waddr < NODES)) mem_q[img_waddr] <= img_wdata;
    if (rd_en) rd_q <= mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wc_q       <= '0;
      step_q     <= '0;
      fc_valid_q <= 1'b0;
      fc_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      step_q     <= step_d;
      fc_valid_q <= fc_valid_d;
      fc_data_q  <= fc_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (wc_q == NODES) state_d = S_WAIT;
      S_WAIT:   if (spk_en) state_d = (step_q == STEP_LAST) ? S_FINISH : S_STREAM;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pixel k is read during window cycle k-1, registered into fc_data at cycle k+1.
  always_comb begin
    win_start  = ((state_q == S_IDLE) && start) ||
                 ((state_q == S_WAIT) && spk_en && (step_q != STEP_LAST));
    pix_cycle  = (state_q == S_STREAM) && (wc_q != NODES);
    rd_addr    = win_start ? 10'd0 : wc_q + 10'd1;
    rd_en      = win_start || (pix_cycle && (rd_addr < NODES));
    wc_d       = win_start ? 10'd0 : (pix_cycle ? wc_q + 10'd1 : wc_q);
    fc_valid_d = win_start || pix_cycle;
    fc_data_d  = pix_cycle ? sample : '0;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d = '0;
          busy_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (spk_en && (step_q != STEP_LAST)) step_d = step_q + 5'd1;
        else if (spk_en) done_d = 1'b1;
      end
      S_FINISH: begin
        busy_d = 1'b0;
        step_d = '0;
      end
      default: ;
    endcase
  end

`ifdef SNN_RATE_CODE_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == S_IDLE) && start) lfsr_d = LFSR_SEED;
    else if (pix_cycle) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    sample = (rd_q > lfsr_q[7:0]) ? ONE : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign sample = {{(WIDTH-8){1'b0}}, rd_q} << (FRAC - 8);
`endif

  assign fc_valid = fc_valid_q;
  assign fc_data  = fc_data_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_snn_input_streamer.sv
// Scoreboard bench for snn_input_streamer: driver queues expected window samples, monitor checks fc_data and window length.
`timescale 1ns/1ps
module tb_snn_input_streamer;
  localparam int N     = 784;
  localparam int STEPS = 25;
  localparam int FRAC  = 17;

  logic        clk = 1'b0, reset = 1'b1, img_we = 1'b0, start = 1'b0, spk_en = 1'b0;
  logic [9:0]  img_waddr = '0;
  logic [7:0]  img_wdata = '0;
  logic        fc_valid, busy, done;
  logic [23:0] fc_data;
  logic [4:0]  step_idx;

  int          checks = 0, errors = 0, done_cnt = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  img_m [N];
  logic [15:0] lfsr_m = 16'hACE1;

  snn_input_streamer dut (
    .clk(clk), .reset(reset), .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .start(start), .spk_en(spk_en), .fc_valid(fc_valid), .fc_data(fc_data),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected window: cycle 0 is zero, cycle k+1 is the sample for pixel k.
  task automatic push_window();
    exp_q.push_back(24'd0);
    for (int k = 0; k < N; k++) begin
`ifdef SNN_RATE_CODE_EN
      exp_q.push_back((img_m[k] > lfsr_m[7:0]) ? (24'd1 << FRAC) : 24'd0);
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
      exp_q.push_back(24'(img_m[k]) * 24'd512);
`endif
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_spk();
    @(posedge clk); #1 spk_en = 1'b1;
    @(posedge clk); #1 spk_en = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk); #1 img_we = 1'b1; img_waddr = a; img_wdata = d;
    @(posedge clk); #1 img_we = 1'b0;
  endtask

  task automatic wait_fall(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!fc_valid) return;
    end
    checks++; errors++;
    $display("FAIL %s_timeout: fc_valid still 1 after 2000 cycles", name);
  endtask

  // Monitor: pops one expected sample per valid cycle and checks each window's length.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (reset) run = 0;
      else if (fc_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sample: got 0x%0h with no expected value", fc_data);
        end else chk("fc_data", 32'(fc_data), 32'(exp_q.pop_front()));
      end else if (run > 0) begin
        chk("window_len", run, N + 1);
        run = 0;
      end
    end
  end

  initial begin
    int bad;
    @(negedge clk);
    chk("rst_fc_valid", 32'(fc_valid), 0);
    chk("rst_fc_data", 32'(fc_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step", 32'(step_idx), 0);
    @(posedge clk); #1 reset = 1'b0;

    @(posedge clk); #1 img_we = 1'b1;
    for (int k = 0; k < N; k++) begin
      img_waddr = 10'(k); img_wdata = 8'(k); img_m[k] = 8'(k);
      @(posedge clk); #1;
    end
    img_we = 1'b0;

    // Full inference with spk_en echoed a few cycles after each window.
    lfsr_m = 16'hACE1;
    push_window();
    pulse_start();
    @(negedge clk);
    chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(fc_valid), 1);
    chk("start_step", 32'(step_idx), 0);
    for (int s = 0; s < STEPS; s++) begin
      wait_fall("window");
      chk("wait_step", 32'(step_idx), 32'(s));
      chk("wait_data", 32'(fc_data), 0);
      repeat (3) @(posedge clk);
      if (s < STEPS - 1) push_window();
      pulse_spk();
      @(negedge clk);
      if (s < STEPS - 1) begin
        chk("next_valid", 32'(fc_valid), 1);
        chk("next_step", 32'(step_idx), 32'(s + 1));
      end else begin
        chk("fin_done", 32'(done), 1);
        chk("fin_busy_hold", 32'(busy), 1);
        chk("fin_valid", 32'(fc_valid), 0);
        @(negedge clk);
        chk("fin_done_clear", 32'(done), 0);
        chk("fin_busy_clear", 32'(busy), 0);
        chk("fin_step", 32'(step_idx), 0);
      end
    end
    chk("done_count", done_cnt, 1);
    chk("sb_empty_1", exp_q.size(), 0);

    // spk_en in IDLE is ignored.
    pulse_spk();
    @(negedge clk);
    chk("idle_spk_busy", 32'(busy), 0);
    chk("idle_spk_valid", 32'(fc_valid), 0);

    // Handshake gating: no spk_en for 1000 cycles after the first window.
    lfsr_m = 16'hACE1;
    push_window();
    pulse_start();
    wait_fall("gate_window");
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fc_valid || step_idx != 5'd0) bad++;
    end
    chk("gating", bad, 0);
    push_window();
    pulse_spk();
    @(negedge clk);
    chk("gate_resume_valid", 32'(fc_valid), 1);
    chk("gate_resume_step", 32'(step_idx), 1);

    // Mid-window start, spk_en and a buffer write must all be dropped.
    repeat (100) @(posedge clk);
    #1 start = 1'b1; spk_en = 1'b1; img_we = 1'b1; img_waddr = 10'd0; img_wdata = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0; spk_en = 1'b0; img_we = 1'b0;
    wait_fall("busy_window");
    chk("busy_step", 32'(step_idx), 1);
    push_window();
    pulse_spk();
    @(negedge clk);
    chk("busy_next_step", 32'(step_idx), 2);

    // Reset at window cycle 400.
    repeat (400) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(fc_valid), 0);
    chk("mid_rst_data", 32'(fc_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_step", 32'(step_idx), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;

    // Out-of-range write dropped; an in-range write lands.
    wr(10'd800, 8'h5A);
    wr(10'd783, 8'h11);
    img_m[783] = 8'h11;

    lfsr_m = 16'hACE1;
    push_window();
    pulse_start();
    @(negedge clk);
    chk("post_rst_step", 32'(step_idx), 0);
    chk("post_rst_valid", 32'(fc_valid), 1);
    wait_fall("post_rst_window");
    chk("sb_empty_2", exp_q.size(), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snn_input_streamer.md
# snn_input_streamer

Drives the serial pixel stream into the first fully-connected LIF layer for every time step of one inference. A 784-entry 8-bit image buffer is loaded by the host. On `start`, the block emits one input window per time step: `fc_valid` is held for INPUT_NODES+1 cycles and `fc_data` carries Q-format samples. After each window it waits for the layer's spike-ready pulse, and repeats for STEP steps. It sits between the image loader and the FC1/LIF1 layer, at the transmit end of that layer's input interface.

## Interface
- WIDTH, 24: sample width, signed fixed point.
- FRAC, 17: fraction bits of `fc_data`; must be ≥ 8.
- STEP, 25: time steps per inference.
- INPUT_NODES, 784: pixels per image.
- LFSR_SEED, 16'hACE1: LFSR seed loaded on `start`; must be non-zero.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- img_we  in  1  image buffer write strobe
- img_waddr  in  10  pixel address, 0..INPUT_NODES-1
- img_wdata  in  8  unsigned pixel
- start  in  1  single-cycle inference start
- spk_en  in  1  layer step-complete pulse, from the layer's `spk1_en`
- fc_valid  out  1  window-valid signal, to the layer's `fc_addra_valid`
- fc_data  out  WIDTH  signed sample, to the layer's `input_fc_array`
- step_idx  out  5  current step, 0..STEP-1
- busy  out  1  inference in progress
- done  out  1  single-cycle pulse after the last step completes

## Operation
- **Image buffer**
  - Single-port write, synchronous read, INPUT_NODES×8.
  - Writes are accepted only while `busy`=0; writes while busy are dropped.
  - Writes with an address ≥ INPUT_NODES are dropped.
- **State machine:** IDLE, STREAM, WAIT, FINISH.
  - IDLE: when `start`=1, set `step_idx`=0, load LFSR_SEED, assert `busy`, go to STREAM. `start` is ignored in every other state.
  - STREAM: the window counter `wc` runs 0..INPUT_NODES (785 cycles), with `fc_valid`=1 for the whole window. At `wc`=INPUT_NODES, go to WAIT.
  - WAIT: `fc_valid`=0 and `fc_data`=0. On `spk_en`:
    - if `step_idx`=STEP-1, go to FINISH;
    - otherwise increment `step_idx` and go to STREAM (the next window starts the following cycle).
  - FINISH: pulse `done` for one cycle, clear `busy`, set `step_idx`=0, go to IDLE.
- **Window data alignment**
  - Window cycle 0 carries `fc_data`=0.
  - Window cycle k+1 (k=0..INPUT_NODES-1) carries the sample for pixel k, which lines up with the layer's one-cycle weight ROM latency.
  - The buffer read address is issued one cycle ahead of the sample.
- **Spurious handshakes:** an `spk_en` seen in IDLE or STREAM is ignored; it is neither counted nor stored.
- **Reset:** asserting `reset` at any point, including mid-window, returns to IDLE immediately. Buffer contents are not cleared.

## Timing
- Reset values: `fc_valid`=0, `fc_data`=0, `busy`=0, `done`=0, `step_idx`=0, state IDLE.
- All outputs are registered.
- `start` at cycle t gives `busy`=1 and `fc_valid`=1 at t+1. `fc_valid` falls at t+786.
- Next window: `spk_en` at cycle s gives `fc_valid`=1 at s+1.
- Final step: `spk_en` at cycle s gives `done`=1 at s+1 and `busy`=0 at s+2.
- `fc_valid` never has a gap inside a window and is never high for more than INPUT_NODES+1 consecutive cycles.

## Configuration
- **`SNN_RATE_CODE_EN` defined: Bernoulli rate coding.**
  - A 16-bit Fibonacci LFSR shifts left with feedback l[15]^l[13]^l[12]^l[10] and advances once per pixel sample cycle.
  - Sample = 1<<FRAC (1.0) if pixel > lfsr[7:0], else 0.
  - The LFSR is reseeded only on `start`.
- **`SNN_RATE_CODE_EN` undefined: direct current injection.**
  - Sample = zero-extended pixel << (FRAC-8), i.e. pixel/256. For example, pixel 255 gives 0x01FE00 at FRAC=17.
  - Every step repeats identical data.
  - The LFSR is not instantiated.

## Test plan
- **Direct mode stream:** load pixel k = k mod 256, `start`, echo `spk_en` 4 cycles after `fc_valid` falls.
  - Required: 25 windows, each exactly 785 cycles.
  - Window cycle 1 shows 0x000000; cycle 256 shows 0x01FE00 (pixel 255).
  - `done` pulses once; `step_idx` goes 0..24 then back to 0.
- **Handshake gating:** withhold `spk_en` for 1000 cycles after the first window.
  - Required: `fc_valid` stays 0 and `step_idx` stays 0.
  - `spk_en` at cycle s gives `fc_valid`=1 at s+1.
- **Ignored stimulus during busy:** pulse `start` and `spk_en` mid-window, and write pixel 0 = 0xFF during busy.
  - Required: window length unchanged, `step_idx` unchanged, and pixel 0 keeps its old value in the next step.
- **Reset mid-window:** assert `reset` at window cycle 400.
  - Required: all outputs at reset values the same cycle.
  - A later `start` produces a full 785-cycle window from step 0.
- **Rate mode (`SNN_RATE_CODE_EN`):**
  - All pixels 0 gives all-zero samples.
  - All pixels 255 gives 1.0 except when lfsr[7:0]=255.
  - Two `start`s produce bit-identical sample sequences.
- **Address bound:** write `img_waddr`=800.
  - Required: no buffer entry changes.
